// File: rtl/n64adv_joybus_tx_pkg.sv
// Shared Joybus constants: transmitter state encoding, phase lengths in microseconds and
// console command codes. The passive controller sniffer uses the same definitions.
package n64adv_joybus_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StStopLow,
    StGuard
  } joy_state_e;

  // Bit cell is 4 us; a '1' is short-low, a '0' is long-low.
  localparam int unsigned BitCellUs     = 4;
  localparam int unsigned BitOneLowUs   = 1;
  localparam int unsigned BitZeroLowUs  = 3;
  localparam int unsigned StopConsoleUs = 1;
  localparam int unsigned StopCtrlUs    = 2;
  localparam int unsigned MaxBits       = 32;

  localparam logic [7:0] CmdStatus = 8'h00;
  localparam logic [7:0] CmdPoll   = 8'h01;

  function automatic int unsigned bit_low_us(logic b);
    return b ? BitOneLowUs : BitZeroLowUs;
  endfunction

  function automatic int unsigned bit_high_us(logic b);
    return BitCellUs - bit_low_us(b);
  endfunction

endpackage

// File: rtl/n64adv_joybus_phase_timer.sv
// Loadable phase down-counter with a zero flag.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   load_i          : load load_val_i this cycle (takes priority over counting)
//   load_val_i      : phase length minus one
//   zero_o          : counter is zero (last cycle of the current phase)
module n64adv_joybus_phase_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/n64adv_joybus_tx.sv
// Joybus bit-level transmitter: sends tx_nbits payload bits MSB first, then a stop bit, then
// holds the line released for a guard time before signalling tx_done.
//   CLK_4M, nRST   : bit clock, asynchronous active-low reset
//   tx_start       : request (sampled only when idle); tx_data/tx_nbits/tx_stop_ctrl latched
//   CTRL_IN        : raw line level (collision detection only)
//   CTRL_DRV       : 1 = pull CTRL low
//   tx_busy        : frame in progress, up to and including the tx_done cycle
//   tx_done, tx_err: one-cycle pulses (end of guard; illegal request or collision)
// Optional feature macro: JOYBUS_TX_COLLISION_EN (collision abort while the line is released).
module n64adv_joybus_tx
  import n64adv_joybus_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 4,
  parameter int unsigned GUARD_US   = 2
) (
  input  logic        CLK_4M,
  input  logic        nRST,
  input  logic        tx_start,
  input  logic [31:0] tx_data,
  input  logic [5:0]  tx_nbits,
  input  logic        tx_stop_ctrl,
  input  logic        CTRL_IN,
  output logic        CTRL_DRV,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err
);

  localparam int unsigned PhW = $clog2(3 * CLK_PER_US + 1);

  function automatic logic [PhW-1:0] us_cycles(int unsigned us);
    return PhW'(us * CLK_PER_US - 1);
  endfunction

  joy_state_e     state_q, state_d;
  logic [31:0]    shift_q, shift_d;
  logic [4:0]     bits_q, bits_d;
  logic           stop_q, stop_d;
  logic           err_q, err_d;
  logic           ph_load;
  logic [PhW-1:0] ph_val;
  logic           ph_zero;
  logic           collision;

  n64adv_joybus_phase_timer #(
    .Width(PhW)
  ) u_phase_timer (
    .clk_i     (CLK_4M),
    .rst_ni    (nRST),
    .load_i    (ph_load),
    .load_val_i(ph_val),
    .zero_o    (ph_zero)
  );

`ifdef JOYBUS_TX_COLLISION_EN
  logic [1:0] sync_q;
  logic [1:0] skip_q;

  // skip_q saturates at 2: the first two cycles of each phase are ignored so the
  // synchroniser can flush our own low drive before the line is judged.
  always_ff @(posedge CLK_4M or negedge nRST) begin
    if (!nRST) begin
      sync_q <= 2'b11;
      skip_q <= '0;
    end else begin
      sync_q <= {sync_q[0], CTRL_IN};
      if (ph_load) begin
        skip_q <= '0;
      end else if (skip_q != 2'd2) begin
        skip_q <= skip_q + 2'd1;
      end
    end
  end

  assign collision = ((state_q == StHigh) || (state_q == StGuard)) &&
                     (skip_q == 2'd2) && !sync_q[1];
`else
  logic unused_ctrl_in;
  assign unused_ctrl_in = CTRL_IN;
  assign collision      = 1'b0;
`endif

  always_ff @(posedge CLK_4M or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      shift_q <= '0;
      bits_q  <= '0;
      stop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    stop_d  = stop_q;
    err_d   = 1'b0;
    ph_load = 1'b0;
    ph_val  = '0;
    tx_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          if ((tx_nbits != 6'd0) && (tx_nbits <= 6'(MaxBits))) begin
            state_d = StLow;
            shift_d = tx_data;
            bits_d  = 5'(tx_nbits - 6'd1);
            stop_d  = tx_stop_ctrl;
            ph_load = 1'b1;
            ph_val  = us_cycles(bit_low_us(tx_data[31]));
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLow: begin
        if (ph_zero) begin
          state_d = StHigh;
          ph_load = 1'b1;
          ph_val  = us_cycles(bit_high_us(shift_q[31]));
        end
      end
      StHigh: begin
        if (ph_zero) begin
          shift_d = {shift_q[30:0], 1'b0};
          ph_load = 1'b1;
          if (bits_q == 5'd0) begin
            state_d = StStopLow;
            ph_val  = us_cycles(stop_q ? StopCtrlUs : StopConsoleUs);
          end else begin
            bits_d  = bits_q - 5'd1;
            state_d = StLow;
            ph_val  = us_cycles(bit_low_us(shift_q[30]));
          end
        end
      end
      StStopLow: begin
        if (ph_zero) begin
          state_d = StGuard;
          ph_load = 1'b1;
          ph_val  = us_cycles(GUARD_US);
        end
      end
      StGuard: begin
        if (ph_zero) begin
          state_d = StIdle;
          tx_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Collision abandons the frame: release, flag, and park the timer.
    if (collision) begin
      state_d = StIdle;
      err_d   = 1'b1;
      tx_done = 1'b0;
      ph_load = 1'b1;
      ph_val  = '0;
    end
  end

  assign CTRL_DRV = (state_q == StLow) || (state_q == StStopLow);
  assign tx_busy  = (state_q != StIdle);
  assign tx_err   = err_q;

endmodule

// File: tb/tb_n64adv_joybus_tx.sv
module tb_n64adv_joybus_tx;

  logic        CLK_4M = 1'b0;
  logic        nRST = 1'b0;
  logic        tx_start = 1'b0;
  logic [31:0] tx_data = '0;
  logic [5:0]  tx_nbits = '0;
  logic        tx_stop_ctrl = 1'b0;
  logic        ext_low = 1'b0;
  logic        CTRL_IN;
  logic        CTRL_DRV, tx_busy, tx_done, tx_err;

  // Open-drain line: low if we drive it or an external device pulls it.
  assign CTRL_IN = ~CTRL_DRV & ~ext_low;

  always #5 CLK_4M = ~CLK_4M;

  n64adv_joybus_tx dut (
    .CLK_4M      (CLK_4M),
    .nRST        (nRST),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_nbits    (tx_nbits),
    .tx_stop_ctrl(tx_stop_ctrl),
    .CTRL_IN     (CTRL_IN),
    .CTRL_DRV    (CTRL_DRV),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  localparam int Us = 4;

  int n_pass = 0;
  int n_total = 0;

  bit got_drv[$];
  bit exp_drv[$];
  int busy_len, done_at, n_done, err_seen;
  logic [31:0] dec_bits;
  int dec_n, dec_stop, dec_bad;

  // Reference waveform from the protocol rules: per bit a 4 us cell, '1' = 1 us low,
  // '0' = 3 us low; then 1/2 us stop low; then 2 us released guard.
  task automatic build_exp(input logic [31:0] d, input int nb, input logic stp);
    int lo;
    exp_drv.delete();
    for (int i = 0; i < nb; i++) begin
      lo = d[31-i] ? 1 * Us : 3 * Us;
      for (int j = 0; j < lo; j++) exp_drv.push_back(1'b1);
      for (int j = 0; j < 4 * Us - lo; j++) exp_drv.push_back(1'b0);
    end
    for (int j = 0; j < (stp ? 2 : 1) * Us; j++) exp_drv.push_back(1'b1);
    for (int j = 0; j < 2 * Us; j++) exp_drv.push_back(1'b0);
  endtask

  function automatic int wave_err();
    int e = 0;
    if (got_drv.size() != exp_drv.size() + 1) e++;
    for (int i = 0; i < exp_drv.size(); i++) begin
      if (i >= got_drv.size()) e++;
      else if (got_drv[i] != exp_drv[i]) e++;
    end
    if (got_drv.size() > exp_drv.size() && got_drv[exp_drv.size()]) e++;
    return e;
  endfunction

  // Decode low pulse widths: all runs but the last are data bits, the last is the stop.
  task automatic decode_got();
    int run;
    int runs[$];
    run = 0;
    for (int i = 0; i < got_drv.size(); i++) begin
      if (got_drv[i]) run++;
      else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    if (run != 0) runs.push_back(run);
    dec_bits = '0;
    dec_n = 0;
    dec_bad = 0;
    dec_stop = 0;
    for (int i = 0; i < runs.size(); i++) begin
      if (i == runs.size() - 1) dec_stop = runs[i];
      else begin
        if (runs[i] != Us && runs[i] != 3 * Us) dec_bad++;
        dec_bits = {dec_bits[30:0], (runs[i] == Us)};
        dec_n++;
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input int nb, input logic stp);
    tx_data = d;
    tx_nbits = 6'(nb);
    tx_stop_ctrl = stp;
    tx_start = 1'b1;
    @(negedge CLK_4M);
    tx_start = 1'b0;
  endtask

  // Sample k = 1.. starting at the negedge after the accepting edge; stops at the first
  // sample with tx_busy low (recorded) or after limit samples.
  task automatic capture(input int limit, input int dup_at, input int ext_from, input int ext_len);
    got_drv.delete();
    busy_len = 0;
    done_at = -1;
    n_done = 0;
    err_seen = 0;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge CLK_4M);
      got_drv.push_back(CTRL_DRV);
      if (tx_done) begin
        n_done++;
        done_at = k;
      end
      if (tx_err) err_seen++;
      if (!tx_busy) break;
      busy_len++;
      tx_start = (k == dup_at);
      ext_low = (k >= ext_from) && (k < ext_from + ext_len);
    end
    tx_start = 1'b0;
    ext_low = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({CTRL_DRV, tx_busy, tx_done, tx_err} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {CTRL_DRV, tx_busy, tx_done, tx_err});
    else n_pass++;
    repeat (3) @(negedge CLK_4M);
    nRST = 1'b1;
    @(negedge CLK_4M);
    n_total++;
    if ({CTRL_DRV, tx_busy, tx_done, tx_err} !== 4'b0000)
      $display("FAIL reset_release_idle: got %b expected 0000",
               {CTRL_DRV, tx_busy, tx_done, tx_err});
    else n_pass++;
  endtask

  task automatic test_console_frame();
    @(negedge CLK_4M);
    build_exp(32'h0100_0000, 8, 1'b0);
    send(32'h0100_0000, 8, 1'b0);
    capture(200, 0, 0, 0);
    decode_got();
    n_total++;
    if (wave_err() != 0) $display("FAIL console_wave: got %0d bad samples expected 0", wave_err());
    else n_pass++;
    n_total++;
    if (done_at != 140 || n_done != 1)
      $display("FAIL console_done: got cycle %0d x%0d expected cycle 140 x1", done_at, n_done);
    else n_pass++;
    n_total++;
    if (busy_len != 140) $display("FAIL console_busy: got %0d expected 140", busy_len);
    else n_pass++;
    n_total++;
    if (dec_stop != 4 || dec_n != 8 || dec_bits != 32'h01 || dec_bad != 0)
      $display("FAIL console_decode: got bits %h n %0d stop %0d expected 01 8 4",
               dec_bits, dec_n, dec_stop);
    else n_pass++;
  endtask

  task automatic test_controller_frame();
    @(negedge CLK_4M);
    build_exp(32'hA5A5_0F0F, 32, 1'b1);
    send(32'hA5A5_0F0F, 32, 1'b1);
    capture(600, 0, 0, 0);
    decode_got();
    n_total++;
    if (dec_bits != 32'hA5A5_0F0F || dec_n != 32 || dec_bad != 0)
      $display("FAIL ctrl_decode: got %h (%0d bits) expected a5a50f0f (32 bits)", dec_bits, dec_n);
    else n_pass++;
    n_total++;
    if (dec_stop != 8) $display("FAIL ctrl_stop_len: got %0d expected 8", dec_stop);
    else n_pass++;
    n_total++;
    if (done_at != 528 || n_done != 1 || busy_len != 528)
      $display("FAIL ctrl_done: got cycle %0d x%0d busy %0d expected 528 x1 busy 528",
               done_at, n_done, busy_len);
    else n_pass++;
    n_total++;
    if (wave_err() != 0) $display("FAIL ctrl_wave: got %0d bad samples expected 0", wave_err());
    else n_pass++;
  endtask

  task automatic test_reject();
    int bad_nb[3];
    bad_nb[0] = 0;
    bad_nb[1] = 33;
    bad_nb[2] = $urandom_range(34, 63);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_4M);
      send($urandom, bad_nb[i], 1'($urandom));
      n_total++;
      if ({tx_err, CTRL_DRV, tx_busy} !== 3'b100)
        $display("FAIL reject_pulse nbits=%0d: got err/drv/busy %b expected 100",
                 bad_nb[i], {tx_err, CTRL_DRV, tx_busy});
      else n_pass++;
      @(negedge CLK_4M);
      n_total++;
      if ({tx_err, CTRL_DRV, tx_busy} !== 3'b000)
        $display("FAIL reject_after nbits=%0d: got err/drv/busy %b expected 000",
                 bad_nb[i], {tx_err, CTRL_DRV, tx_busy});
      else n_pass++;
    end
  endtask

  task automatic test_ignore_busy();
    @(negedge CLK_4M);
    build_exp(32'h0100_0000, 8, 1'b0);
    send(32'h0100_0000, 8, 1'b0);
    capture(300, 20, 0, 0);
    n_total++;
    if (wave_err() != 0 || n_done != 1 || done_at != 140)
      $display("FAIL ignore_busy: got %0d bad samples, %0d done at %0d expected 0, 1 at 140",
               wave_err(), n_done, done_at);
    else n_pass++;
    repeat (200) @(negedge CLK_4M);
    n_total++;
    if (tx_busy !== 1'b0 || CTRL_DRV !== 1'b0)
      $display("FAIL ignore_no_queue: got busy %b drv %b expected 0 0", tx_busy, CTRL_DRV);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int nb;
    @(negedge CLK_4M);
    build_exp(32'h8000_0000, 1, 1'b0);
    send(32'h8000_0000, 1, 1'b0);
    capture(100, 0, 0, 0);
    n_total++;
    if (wave_err() != 0 || done_at != 28)
      $display("FAIL b2b_first: got %0d bad, done at %0d expected 0, 28", wave_err(), done_at);
    else n_pass++;
    d = $urandom;
    nb = $urandom_range(1, 32);
    build_exp(d, nb, 1'b1);
    send(d, nb, 1'b1);  // issued in the first idle cycle
    capture(700, 0, 0, 0);
    n_total++;
    if (wave_err() != 0 || n_done != 1 || done_at != exp_drv.size())
      $display("FAIL b2b_second: got %0d bad, done at %0d expected 0, %0d",
               wave_err(), done_at, exp_drv.size());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    int nb;
    logic stp;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      nb = (i == 0) ? 32 : (i == 1) ? 1 : $urandom_range(1, 32);
      stp = 1'($urandom);
      @(negedge CLK_4M);
      build_exp(d, nb, stp);
      send(d, nb, stp);
      capture(700, 0, 0, 0);
      decode_got();
      n_total++;
      if (wave_err() != 0 || n_done != 1 || done_at != 16 * nb + (stp ? 8 : 4) + 8 ||
          busy_len != done_at || err_seen != 0)
        $display("FAIL random_frame %0d (d=%h nb=%0d stp=%0d): got %0d bad done %0d expected 0 %0d",
                 i, d, nb, stp, wave_err(), done_at, 16 * nb + (stp ? 8 : 4) + 8);
      else n_pass++;
      n_total++;
      if (dec_bits != (d >> (32 - nb)) || dec_n != nb)
        $display("FAIL random_decode %0d: got %h expected %h", i, dec_bits, d >> (32 - nb));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(negedge CLK_4M);
    send(32'h0100_0000, 8, 1'b0);
    repeat (49) @(negedge CLK_4M);  // cycle 50: low phase of bit 3
    n_total++;
    if (CTRL_DRV !== 1'b1 || tx_busy !== 1'b1)
      $display("FAIL mid_frame_drive: got drv %b busy %b expected 1 1", CTRL_DRV, tx_busy);
    else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_total++;
    if ({CTRL_DRV, tx_busy, tx_done, tx_err} !== 4'b0000)
      $display("FAIL async_reset: got %b expected 0000", {CTRL_DRV, tx_busy, tx_done, tx_err});
    else n_pass++;
    repeat (3) @(negedge CLK_4M);
    nRST = 1'b1;
    repeat (2) @(negedge CLK_4M);
    n_total++;
    if ({CTRL_DRV, tx_busy} !== 2'b00)
      $display("FAIL no_resume: got drv/busy %b expected 00", {CTRL_DRV, tx_busy});
    else n_pass++;
    d = $urandom;
    build_exp(d, 16, 1'b0);
    send(d, 16, 1'b0);
    capture(400, 0, 0, 0);
    n_total++;
    if (wave_err() != 0 || n_done != 1 || done_at != 268)
      $display("FAIL post_reset_frame: got %0d bad, done at %0d expected 0, 268",
               wave_err(), done_at);
    else n_pass++;
  endtask

  task automatic test_collision();
    // Bit 2 occupies cycles 33..48; with a '1' its high phase starts at 37.
    @(negedge CLK_4M);
    build_exp(32'hFF00_0000, 8, 1'b0);
    send(32'hFF00_0000, 8, 1'b0);
    capture(300, 0, 42, 6);
`ifdef JOYBUS_TX_COLLISION_EN
    n_total++;
    if (err_seen != 1 || n_done != 0)
      $display("FAIL collision_flags: got err %0d done %0d expected 1 0", err_seen, n_done);
    else n_pass++;
    n_total++;
    if (busy_len > 45 || got_drv[got_drv.size()-1] != 1'b0)
      $display("FAIL collision_idle: got busy until %0d expected <= 45", busy_len);
    else n_pass++;
`else
    n_total++;
    if (wave_err() != 0 || n_done != 1 || done_at != 140 || err_seen != 0)
      $display("FAIL collision_ignored: got %0d bad, done %0d at %0d, err %0d expected 0 1 140 0",
               wave_err(), n_done, done_at, err_seen);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_console_frame();
    test_controller_frame();
    test_reject();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_collision();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
